jtdd2_snd_cmd: RTL and testbench

Main-CPU-side sound command transmitter for the Double Dragon 2 core: buffers command bytes written by the main CPU and delivers them one at a time to the sound subsystem. Each command is presented on `snd_latch` with a `snd_irq` pulse, and the block waits for the sound CPU to read the latch before sending the next one. It also owns the sound CPU reset line `snd_rstb`. It sits between the main CPU address decoder and the sound board's `snd_latch`/`snd_irq`/`snd_rstb` inputs.

---
 rtl/jtdd2_snd_pkg.sv | 16 +
 rtl/jtdd2_snd_fifo.sv | 62 ++++++
 rtl/jtdd2_snd_cmd.sv | 146 ++++++++++++++
 tb/tb_jtdd2_snd_cmd.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd2_snd_pkg.sv
// Shared definitions for the Double Dragon 2 sound command path.
// Provides the transmitter FSM state type and the default pulse and
// acknowledge-timeout lengths.
package jtdd2_snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_IRQ  = 2'd2,
    ST_WAIT = 2'd3
  } snd_state_t;

  localparam int unsigned DEF_IRQ_LEN = 8;
  localparam int unsigned DEF_TIMEOUT = 4096;

endpackage

// File: rtl/jtdd2_snd_fifo.sv
// Synchronous FIFO for sound command bytes.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, din      write strobe and data
//   pop            read strobe (head advances)
//   dout           current head entry
//   full, empty    occupancy flags
//   count          number of stored entries (AW+1 bits)
//   drop           a push was refused this cycle (full, no pop)
// A push while full is accepted when a pop happens in the same cycle.
module jtdd2_snd_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          drop
);

  localparam int unsigned DEPTH = 2**AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jtdd2_snd_cmd.sv
// Main-CPU side sound command transmitter.
// Buffers command bytes and presents them one at a time on snd_latch with
// an snd_irq pulse, waiting for the sound CPU to read the latch (snd_ack
// rising edge) or for a timeout before sending the next one. Also owns the
// sound CPU reset line snd_rstb.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_we, cmd_din       push a command byte
//   ctl_we, ctl_din       write snd_rstb
//   snd_ack               sound CPU latch read select (level)
//   snd_latch, snd_irq    command byte and interrupt to the sound CPU
//   snd_rstb              sound CPU reset, active-low
//   full, busy            FIFO full; work pending or in flight
//   ovf, lost             sticky: push dropped; command timed out
module jtdd2_snd_cmd
  import jtdd2_snd_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned IRQ_LEN = DEF_IRQ_LEN,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_we,
  input  logic [7:0] cmd_din,
  input  logic       ctl_we,
  input  logic       ctl_din,
  input  logic       snd_ack,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       snd_rstb,
  output logic       full,
  output logic       busy,
  output logic       ovf,
  output logic       lost
);

  localparam int unsigned IRQ_CW = (IRQ_LEN > 1) ? $clog2(IRQ_LEN) : 1;
  localparam int unsigned TO_CW  = $clog2(TIMEOUT);
  localparam logic [IRQ_CW-1:0] IRQ_LOAD = IRQ_CW'(IRQ_LEN - 1);
  localparam logic [TO_CW-1:0]  TO_LAST  = TO_CW'(TIMEOUT - 1);

  snd_state_t        state, state_nxt;
  logic              ack_q, ack_rise, ack_seen;
  logic [IRQ_CW-1:0] irq_cnt;
  logic [TO_CW-1:0]  to_cnt;
  logic              hold, pop, timeout, push_ok;
  logic [7:0]        fifo_head;
  logic              fifo_empty, fifo_drop;
  logic [FIFO_AW:0]  fifo_cnt, cnt_nxt;

  jtdd2_snd_fifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_we),
    .pop   (pop),
    .din   (cmd_din),
    .dout  (fifo_head),
    .full  (full),
    .empty (fifo_empty),
    .count (fifo_cnt),
    .drop  (fifo_drop)
  );

  assign ack_rise = snd_ack & ~ack_q;
  // A ctl write clearing snd_rstb acts in the same cycle it is written.
  assign hold     = ~snd_rstb | (ctl_we & ~ctl_din);
  assign push_ok  = cmd_we & (~full | pop);
  assign cnt_nxt  = fifo_cnt + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (hold) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!fifo_empty) state_nxt = ST_LOAD;
        ST_LOAD: state_nxt = ST_IRQ;
        ST_IRQ:  if (irq_cnt == '0)
                   state_nxt = (ack_seen | ack_rise) ? ST_IDLE : ST_WAIT;
        ST_WAIT: if (ack_rise || to_cnt == TO_LAST) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pop     = (state == ST_LOAD) & ~hold;
    timeout = (state == ST_WAIT) & ~hold & ~ack_rise & (to_cnt == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      ack_seen  <= 1'b0;
      snd_rstb  <= 1'b0;
      snd_latch <= '0;
      snd_irq   <= 1'b0;
      irq_cnt   <= '0;
      to_cnt    <= '0;
      ovf       <= 1'b0;
      lost      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ack_q <= snd_ack;
      if (ctl_we) snd_rstb <= ctl_din;
      ovf  <= ovf | fifo_drop;
      lost <= lost | timeout;
      // Built from next-cycle values so busy matches the registered state.
      busy <= (cnt_nxt != '0) | (state_nxt != ST_IDLE);

      if (state_nxt == ST_IDLE)            ack_seen <= 1'b0;
      else if (state == ST_IRQ && ack_rise) ack_seen <= 1'b1;

      if (hold) begin
        snd_irq <= 1'b0;
        irq_cnt <= '0;
        to_cnt  <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            snd_latch <= fifo_head;
            snd_irq   <= 1'b1;
            irq_cnt   <= IRQ_LOAD;
            to_cnt    <= '0;
          end
          ST_IRQ: begin
            if (irq_cnt == '0) snd_irq <= 1'b0;
            else               irq_cnt <= irq_cnt - 1'b1;
          end
          ST_WAIT: to_cnt <= (state_nxt == ST_WAIT) ? to_cnt + 1'b1 : '0;
          default: to_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtdd2_snd_cmd.sv
// Directed bench for jtdd2_snd_cmd with random command bytes and ack delays.
// Expected delivery order comes from a queue of accepted pushes; pulse
// length, gaps and latch stability are checked by an event monitor.
module tb_jtdd2_snd_cmd;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned IRQ_LEN = 8;
  localparam int unsigned TIMEOUT = 4096;
  localparam int unsigned LIMIT   = 2 * (IRQ_LEN + TIMEOUT) + 100;

  logic       clk, rst_n, cmd_we, ctl_we, ctl_din, snd_ack;
  logic [7:0] cmd_din, snd_latch;
  logic       snd_irq, snd_rstb, full, busy, ovf, lost;

  int unsigned vectors = 0;
  int unsigned errs    = 0;
  logic [7:0]  exp_q[$];
  bit          abort_ok = 1'b0;

  jtdd2_snd_cmd #(
    .FIFO_AW (2),
    .IRQ_LEN (IRQ_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_we    (cmd_we),
    .cmd_din   (cmd_din),
    .ctl_we    (ctl_we),
    .ctl_din   (ctl_din),
    .snd_ack   (snd_ack),
    .snd_latch (snd_latch),
    .snd_irq   (snd_irq),
    .snd_rstb  (snd_rstb),
    .full      (full),
    .busy      (busy),
    .ovf       (ovf),
    .lost      (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    cmd_we  = 1'b1;
    cmd_din = b;
    tick();
    cmd_we  = 1'b0;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic set_rstb(input logic v);
    ctl_we  = 1'b1;
    ctl_din = v;
    tick();
    ctl_we  = 1'b0;
  endtask

  task automatic wait_irq(input logic lvl, input string tag);
    int unsigned n = 0;
    while (snd_irq !== lvl && n < LIMIT) begin
      tick();
      n++;
    end
    chk(tag, 32'(snd_irq), 32'(lvl));
  endtask

  // Deliver one command, acknowledging it some random time into WAIT.
  task automatic ack_wait();
    wait_irq(1'b1, "irq_rise");
    wait_irq(1'b0, "irq_fall");
    tick($urandom_range(1, 30));
    snd_ack = 1'b1;
    tick($urandom_range(1, 3));
    snd_ack = 1'b0;
    tick();
  endtask

  // Monitor: order of delivered bytes, pulse length, low gap, latch stability.
  int unsigned hi = 0, lo = 100;
  logic        prev = 1'b0;
  logic [7:0]  held = '0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev = 1'b0;
      hi   = 0;
      lo   = 100;
    end else begin
      if (snd_irq && !prev) begin
        chk("irq_gap_ge2", 32'(lo >= 2), 32'd1);
        chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("latch_order", 32'(snd_latch), 32'(exp_q.pop_front()));
        held = snd_latch;
        hi   = 1;
      end else if (snd_irq) begin
        chk("latch_hold", 32'(snd_latch), 32'(held));
        hi++;
      end else if (prev) begin
        if (!abort_ok) chk("irq_len", hi, IRQ_LEN);
        abort_ok = 1'b0;
        lo = 1;
      end else begin
        lo++;
      end
      prev = snd_irq;
    end
  end

  initial begin
    logic [7:0] a, b, c, d, e, z;
    int unsigned cnt, drops, n;
    bit pop_now, acc;

    rst_n = 1'b0; cmd_we = 1'b0; cmd_din = '0;
    ctl_we = 1'b0; ctl_din = 1'b0; snd_ack = 1'b0;
    tick(3);
    chk("rst_latch", 32'(snd_latch), 32'd0);
    chk("rst_irq",   32'(snd_irq),   32'd0);
    chk("rst_rstb",  32'(snd_rstb),  32'd0);
    chk("rst_full",  32'(full),      32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    chk("rst_lost",  32'(lost),      32'd0);
    rst_n = 1'b1;
    tick();

    // Single command with an ack 20 cycles after the pulse.
    set_rstb(1'b1);
    chk("rstb_set", 32'(snd_rstb), 32'd1);
    push(8'h3A, 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_irq_n0", 32'(snd_irq), 32'd0);
    tick();
    chk("t1_irq_n1", 32'(snd_irq), 32'd0);
    tick();
    chk("t1_irq_n2", 32'(snd_irq), 32'd1);
    chk("t1_latch_n2", 32'(snd_latch), 32'h3A);
    wait_irq(1'b0, "t1_fall");
    tick(20);
    chk("t1_busy_wait", 32'(busy), 32'd1);
    snd_ack = 1'b1;
    tick();
    chk("t1_busy_ack", 32'(busy), 32'd0);
    snd_ack = 1'b0;
    tick();
    chk("t1_lost", 32'(lost), 32'd0);

    // Timeout: pulse plus full wait window, then a normally acked command.
    push(8'h10, 1'b1);
    tick(IRQ_LEN + TIMEOUT + 1);
    chk("t2_lost_before", 32'(lost), 32'd0);
    tick();
    chk("t2_lost_after", 32'(lost), 32'd1);
    chk("t2_idle", 32'(busy), 32'd0);
    push(8'h11, 1'b1);
    ack_wait();
    chk("t2_busy_done", 32'(busy), 32'd0);

    // Back-to-back pushes; the first is popped two edges after its push.
    cnt = 0; drops = 0;
    for (int i = 0; i < 6; i++) begin
      pop_now = (i == 2);
      acc = (cnt < DEPTH) || pop_now;
      push(8'(i + 1), acc);
      cnt = cnt + (acc ? 1 : 0) - (pop_now ? 1 : 0);
      if (!acc) drops++;
      chk("t3_full", 32'(full), 32'(cnt == DEPTH));
      chk("t3_ovf", 32'(ovf), 32'(drops != 0));
    end
    n = 0;
    while (busy && n < 6 * (IRQ_LEN + TIMEOUT + 8)) begin
      tick();
      n++;
    end
    chk("t3_drained", 32'(busy), 32'd0);
    chk("t3_all_sent", exp_q.size(), 32'd0);

    // Ack during the pulse: WAIT is skipped for both commands.
    a = 8'($urandom); b = 8'($urandom);
    push(a, 1'b1);
    push(b, 1'b1);
    wait_irq(1'b1, "t4_rise_a");
    tick(3);
    snd_ack = 1'b1;
    tick();
    snd_ack = 1'b0;
    wait_irq(1'b0, "t4_fall_a");
    chk("t4_busy_b", 32'(busy), 32'd1);
    tick();
    chk("t4_gap1", 32'(snd_irq), 32'd0);
    tick();
    chk("t4_rise_b", 32'(snd_irq), 32'd1);
    tick(2);
    snd_ack = 1'b1;
    tick();
    snd_ack = 1'b0;
    wait_irq(1'b0, "t4_fall_b");
    chk("t4_idle", 32'(busy), 32'd0);

    // Sound reset mid-pulse keeps the queue and the latch.
    c = 8'($urandom); d = 8'($urandom); e = 8'($urandom);
    push(c, 1'b1);
    push(d, 1'b1);
    push(e, 1'b1);
    wait_irq(1'b1, "t5_rise_c");
    tick(2);
    abort_ok = 1'b1;
    set_rstb(1'b0);
    chk("t5_irq_off", 32'(snd_irq), 32'd0);
    chk("t5_rstb", 32'(snd_rstb), 32'd0);
    chk("t5_latch", 32'(snd_latch), 32'(c));
    chk("t5_busy", 32'(busy), 32'd1);
    tick(5);
    chk("t5_irq_held", 32'(snd_irq), 32'd0);
    chk("t5_queue_kept", exp_q.size(), 32'd2);
    set_rstb(1'b1);
    ack_wait();
    ack_wait();
    chk("t5_done", 32'(busy), 32'd0);

    // Asynchronous reset while waiting with two bytes queued.
    push(8'($urandom), 1'b1);
    push(8'($urandom), 1'b1);
    push(8'($urandom), 1'b1);
    wait_irq(1'b1, "t6_rise");
    wait_irq(1'b0, "t6_fall");
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_latch", 32'(snd_latch), 32'd0);
    chk("t6_irq",   32'(snd_irq),   32'd0);
    chk("t6_rstb",  32'(snd_rstb),  32'd0);
    chk("t6_full",  32'(full),      32'd0);
    chk("t6_busy",  32'(busy),      32'd0);
    chk("t6_ovf",   32'(ovf),       32'd0);
    chk("t6_lost",  32'(lost),      32'd0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("t6_busy_rel", 32'(busy), 32'd0);
    set_rstb(1'b1);
    tick(2);
    chk("t6_empty", 32'(busy), 32'd0);
    z = 8'($urandom);
    push(z, 1'b1);
    ack_wait();
    chk("t6_final_idle", 32'(busy), 32'd0);
    chk("t6_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
